// File: rtl/vga_draw_arbiter.sv
// Round-robin arbiter sharing one VGA plot port between NUM_REQ start/done drawing engines.
// Optional watchdog on a granted operation: define VGA_ARB_WATCHDOG_EN (adds the wdog_err port).
module vga_draw_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int WDOG_CYCLES = 20000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   eng_start,
  input  logic [NUM_REQ-1:0]   eng_done,
  input  logic [8*NUM_REQ-1:0] eng_x,
  input  logic [7*NUM_REQ-1:0] eng_y,
  input  logic [3*NUM_REQ-1:0] eng_colour,
  input  logic [NUM_REQ-1:0]   eng_plot,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   complete,
  output logic                 busy,
  output logic [7:0]           vga_x,
  output logic [6:0]           vga_y,
  output logic [2:0]           vga_colour,
  output logic                 vga_plot
`ifdef VGA_ARB_WATCHDOG_EN
  ,
  output logic                 wdog_err
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_t;

  state_t               state, state_n;
  logic [IDX_W-1:0]     last, last_n;
  logic [NUM_REQ-1:0]   grant_n, start_n, complete_n;
  logic                 found;
  logic [IDX_W-1:0]     pick;
  logic                 wdog_hit;

  // Rotating search: index last+1 has highest priority, last itself lowest.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
  end

  // last doubles as the owner index while in RUN/RELEASE.
  always_comb begin
    state_n    = state;
    grant_n    = grant;
    start_n    = eng_start;
    complete_n = '0;
    last_n     = last;
    case (state)
      IDLE: begin
        if (found) begin
          state_n       = RUN;
          grant_n       = '0;
          grant_n[pick] = 1'b1;
          start_n       = '0;
          start_n[pick] = 1'b1;
          last_n        = pick;
        end
      end
      RUN: begin
        if (eng_done[last]) begin
          state_n          = RELEASE;
          start_n          = '0;
          complete_n[last] = 1'b1;
        end else if (wdog_hit) begin
          state_n = RELEASE;
          start_n = '0;
        end
      end
      RELEASE: begin
        if (!eng_done[last]) begin
          state_n = IDLE;
          grant_n = '0;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        start_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      eng_start <= '0;
      complete  <= '0;
      last      <= IDX_W'(NUM_REQ - 1);
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      eng_start <= start_n;
      complete  <= complete_n;
      last      <= last_n;
    end
  end

`ifdef VGA_ARB_WATCHDOG_EN
  logic [14:0] wdog_cnt;

  // Hit on the WDOG_CYCLES-th RUN cycle, so start stays high exactly WDOG_CYCLES cycles.
  assign wdog_hit = (state == RUN) && (wdog_cnt == 15'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      if (state != RUN) wdog_cnt <= '0;
      else              wdog_cnt <= wdog_cnt + 15'd1;
      if (wdog_hit && !eng_done[last]) wdog_err <= 1'b1;
    end
  end
`else
  assign wdog_hit = 1'b0;
`endif

  assign busy = |grant;

  // Pixel path is purely combinational so the adapter sees the plot in the same cycle.
  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          vga_x      = vga_x      | eng_x[8*i +: 8];
          vga_y      = vga_y      | eng_y[7*i +: 7];
          vga_colour = vga_colour | eng_colour[3*i +: 3];
          vga_plot   = vga_plot   | eng_plot[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Randomized bench for vga_draw_arbiter: engine behaviour models plus a transaction-level arbiter model.
module tb_vga_draw_arbiter;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, eng_start, eng_done, eng_plot, grant, complete;
  logic           busy;
  logic [8*N-1:0] eng_x;
  logic [7*N-1:0] eng_y;
  logic [3*N-1:0] eng_colour;
  logic [7:0]     vga_x;
  logic [6:0]     vga_y;
  logic [2:0]     vga_colour;
  logic           vga_plot;

  always #5 clk = ~clk;

  vga_draw_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .req(req), .eng_start(eng_start), .eng_done(eng_done),
    .eng_x(eng_x), .eng_y(eng_y), .eng_colour(eng_colour), .eng_plot(eng_plot),
    .grant(grant), .complete(complete), .busy(busy),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the port, whether its done was already seen, who was served last.
  int         m_owner;
  int         m_last;
  bit         m_seen;
  logic [N-1:0] m_complete;

  // Engine behaviour: finish after len cycles of start, keep done for hold extra cycles.
  int run_cnt [N];
  int len     [N];
  int hold    [N];

  function automatic logic [N-1:0] exp_grant();
    return (m_owner >= 0) ? (N'(1) << m_owner) : '0;
  endfunction

  task automatic model_step();
    int pick;
    if (rst) begin
      m_owner    = -1;
      m_seen     = 1'b0;
      m_last     = N - 1;
      m_complete = '0;
    end else begin
      m_complete = '0;
      if (m_owner < 0) begin
        pick = -1;
        for (int off = 1; off <= N; off++)
          if (pick < 0 && req[(m_last + off) % N]) pick = (m_last + off) % N;
        if (pick >= 0) begin
          m_owner = pick;
          m_last  = pick;
        end
      end else if (!m_seen) begin
        if (eng_done[m_owner]) begin
          m_seen = 1'b1;
          m_complete[m_owner] = 1'b1;
        end
      end else if (!eng_done[m_owner]) begin
        m_owner = -1;
        m_seen  = 1'b0;
      end
    end
  endtask

  task automatic drive(input int cyc);
    if (cyc < 2) begin
      rst = 1'b1;
      req = '1;
    end else begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) req = N'($urandom_range(0, (1 << N) - 1));
    end
    for (int i = 0; i < N; i++) begin
      eng_x[8*i +: 8]      = 8'($urandom);
      eng_y[7*i +: 7]      = 7'($urandom);
      eng_colour[3*i +: 3] = 3'($urandom);
      eng_plot[i]          = 1'($urandom_range(0, 1));
      if (m_owner == i) begin
        if (eng_start[i]) begin
          run_cnt[i]++;
          eng_done[i] = (run_cnt[i] >= len[i]);
        end else if (hold[i] > 0) begin
          hold[i]--;
          eng_done[i] = 1'b1;
        end else begin
          eng_done[i] = 1'b0;
        end
      end else begin
        // Idle engines produce noise that the arbiter must ignore.
        eng_done[i] = 1'($urandom_range(0, 1));
        run_cnt[i]  = 0;
        len[i]      = int'($urandom_range(1, 12));
        hold[i]     = int'($urandom_range(0, 2));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    eng_done = '0;
    eng_plot = '0;
    eng_x = '0;
    eng_y = '0;
    eng_colour = '0;
    m_owner = -1;
    m_seen = 1'b0;
    m_last = N - 1;
    m_complete = '0;
    for (int i = 0; i < N; i++) begin
      run_cnt[i] = 0;
      len[i]     = 5;
      hold[i]    = 0;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      drive(cyc);
      #1;
      if (cyc >= 1) begin
        if (rst || m_owner < 0) begin
          chk("vga_x",      32'(vga_x),      32'(0));
          chk("vga_y",      32'(vga_y),      32'(0));
          chk("vga_colour", 32'(vga_colour), 32'(0));
          chk("vga_plot",   32'(vga_plot),   32'(0));
        end else begin
          chk("vga_x",      32'(vga_x),      32'(eng_x[8*m_owner +: 8]));
          chk("vga_y",      32'(vga_y),      32'(eng_y[7*m_owner +: 7]));
          chk("vga_colour", 32'(vga_colour), 32'(eng_colour[3*m_owner +: 3]));
          chk("vga_plot",   32'(vga_plot),   32'(eng_plot[m_owner]));
        end
      end
      model_step();
      @(posedge clk);
      #1;
      chk("grant",     32'(grant),     32'(exp_grant()));
      chk("eng_start", 32'(eng_start), 32'(m_seen ? '0 : exp_grant()));
      chk("complete",  32'(complete),  32'(m_complete));
      chk("busy",      32'(busy),      32'(m_owner >= 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
